// File: rtl/ped_request.sv
// ---------------------------------------------------------------------------
// ped_request
//
// Pedestrian push-button request controller. The raw active-low button is
// synchronised, debounced, and turned into a single press event on the
// debounced rising edge. A three-state FSM (IDLE / REQ / LOCK) raises a held
// request, drops it on acknowledge and then enforces a cooldown during which
// further presses are discarded and flagged on o_Ignored.
//
// Parameters
//   DEB_CYC   debounce stability window in clock cycles (2 .. 2^24-1)
//   LOCK_CYC  post-acknowledge cooldown in clock cycles (2 .. 2^30-1)
//
// Ports
//   i_Clk      clock, all state changes on the rising edge
//   i_Rst      asynchronous active-high reset
//   i_Push     raw asynchronous button, 0 = pressed
//   i_Ack      consumer acknowledge, sampled on i_Clk
//   o_Req      registered request level, held until acknowledged
//   o_Pressed  registered debounced button level, 1 = pressed
//   o_Lock     high while the cooldown is running
//   o_Ignored  one-cycle pulse when a debounced press is discarded
// ---------------------------------------------------------------------------
module ped_request #(
   parameter int DEB_CYC  = 2_000_000,
   parameter int LOCK_CYC = 1_000_000_000
) (
   input  logic i_Clk,
   input  logic i_Rst,
   input  logic i_Push,
   input  logic i_Ack,
   output logic o_Req,
   output logic o_Pressed,
   output logic o_Lock,
   output logic o_Ignored
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_LOCK = 2'd2
   } state_t;

   localparam logic [23:0] DEB_LAST  = 24'(DEB_CYC - 1);
   localparam logic [29:0] LOCK_LOAD = 30'(LOCK_CYC - 1);

   logic        sync1_q,       sync1_d;
   logic        sync2_q,       sync2_d;
   logic [23:0] deb_cnt_q,     deb_cnt_d;
   logic        pressed_q,     pressed_d;
   logic        pressed_dly_q, pressed_dly_d;
   state_t      state_q,       state_d;
   logic [29:0] lock_cnt_q,    lock_cnt_d;
   logic        req_q,         req_d;
   logic        lock_q,        lock_d;
   logic        ign_q,         ign_d;
   logic        press_evt_s;
   logic        level_s;

   // Synchroniser, debounce counter and debounced level
   always_comb begin
      sync1_d       = i_Push;
      sync2_d       = sync1_q;
      pressed_dly_d = pressed_q;
      pressed_d     = pressed_q;
      deb_cnt_d     = 24'd0;
      // Synchronised button converted to pressed polarity (1 = pressed)
      level_s       = ~sync2_q;
      if (level_s != pressed_q) begin
         if (deb_cnt_q == DEB_LAST) begin
            pressed_d = level_s;
            deb_cnt_d = 24'd0;
         end else begin
            deb_cnt_d = deb_cnt_q + 24'd1;
         end
      end else begin
         deb_cnt_d = 24'd0;
      end
   end

   // A press event is the cycle right after the debounced level rose
   assign press_evt_s = pressed_q & ~pressed_dly_q;

   // FSM next state and registered-output next values
   always_comb begin
      state_d    = state_q;
      lock_cnt_d = lock_cnt_q;
      req_d      = req_q;
      lock_d     = lock_q;
      ign_d      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (press_evt_s) begin
               state_d = ST_REQ;
               req_d   = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_REQ: begin
            // Ack wins over a coincident press; the press is only flagged
            ign_d = press_evt_s;
            if (i_Ack) begin
               state_d    = ST_LOCK;
               req_d      = 1'b0;
               lock_d     = 1'b1;
               lock_cnt_d = LOCK_LOAD;
            end else begin
               state_d = ST_REQ;
            end
         end
         ST_LOCK: begin
            ign_d = press_evt_s;
            if (lock_cnt_q == 30'd0) begin
               state_d = ST_IDLE;
               lock_d  = 1'b0;
            end else begin
               lock_cnt_d = lock_cnt_q - 30'd1;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            lock_cnt_d = 30'd0;
            req_d      = 1'b0;
            lock_d     = 1'b0;
         end
      endcase
   end

   // State registers; synchroniser resets to the released level
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         sync1_q       <= 1'b1;
         sync2_q       <= 1'b1;
         deb_cnt_q     <= 24'd0;
         pressed_q     <= 1'b0;
         pressed_dly_q <= 1'b0;
         state_q       <= ST_IDLE;
         lock_cnt_q    <= 30'd0;
         req_q         <= 1'b0;
         lock_q        <= 1'b0;
         ign_q         <= 1'b0;
      end else begin
         sync1_q       <= sync1_d;
         sync2_q       <= sync2_d;
         deb_cnt_q     <= deb_cnt_d;
         pressed_q     <= pressed_d;
         pressed_dly_q <= pressed_dly_d;
         state_q       <= state_d;
         lock_cnt_q    <= lock_cnt_d;
         req_q         <= req_d;
         lock_q        <= lock_d;
         ign_q         <= ign_d;
      end
   end

   assign o_Req     = req_q;
   assign o_Pressed = pressed_q;
   assign o_Lock    = lock_q;
   assign o_Ignored = ign_q;

endmodule

// File: tb/tb_ped_request.sv
// ---------------------------------------------------------------------------
// tb_ped_request
//
// Bench for ped_request with DEB_CYC=4, LOCK_CYC=20. A behavioural model
// (sample-history window for the debounce, timestamp for the cooldown) is
// compared against the DUT outputs on every falling edge; directed scenarios
// add hand-computed literal expectations, followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_ped_request;

   localparam int DEB = 4;
   localparam int LCK = 20;

   logic clk  = 1'b0;
   logic rst  = 1'b1;
   logic push = 1'b1;
   logic ack  = 1'b0;
   logic req, pressed, lock, ign;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   ped_request #(.DEB_CYC(DEB), .LOCK_CYC(LCK)) dut (
      .i_Clk     (clk),
      .i_Rst     (rst),
      .i_Push    (push),
      .i_Ack     (ack),
      .o_Req     (req),
      .o_Pressed (pressed),
      .o_Lock    (lock),
      .o_Ignored (ign)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit m_req, m_pressed, m_prev, m_lock, m_ign;
   int m_mode;       // 0 idle, 1 requesting, 2 cooling down
   int m_edge;
   int m_lock_end;
   bit hist[$];      // hist[0] = raw button sampled at the previous edge

   task automatic model_reset();
      m_req = 1'b0; m_pressed = 1'b0; m_prev = 1'b0; m_lock = 1'b0; m_ign = 1'b0;
      m_mode = 0; m_edge = 0; m_lock_end = 0;
      hist.delete();
      for (int k = 0; k <= DEB; k++) hist.push_back(1'b1);
   endtask

   task automatic model_step();
      bit ev;
      bit flip;
      ev   = m_pressed && !m_prev;
      flip = 1'b1;
      m_edge++;
      // Synchronised value seen before this edge is the sample from two edges
      // ago; the level flips once the last DEB such values all disagree.
      for (int k = 1; k <= DEB; k++)
         if ((hist[k] == 1'b0) == m_pressed) flip = 1'b0;
      hist.push_front(push);
      void'(hist.pop_back());
      m_prev = m_pressed;
      if (flip) m_pressed = !m_pressed;
      m_ign = 1'b0;
      case (m_mode)
         0: if (ev) begin m_mode = 1; m_req = 1'b1; end
         1: begin
            m_ign = ev;
            if (ack) begin
               m_mode = 2; m_req = 1'b0; m_lock = 1'b1; m_lock_end = m_edge + LCK;
            end
         end
         default: begin
            m_ign = ev;
            if (m_edge == m_lock_end) begin m_mode = 0; m_lock = 1'b0; end
         end
      endcase
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or posedge rst);
         if (rst) model_reset();
         else     model_step();
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            chk("model_req",     req,     m_req);
            chk("model_pressed", pressed, m_pressed);
            chk("model_lock",    lock,    m_lock);
            chk("model_ignored", ign,     m_ign);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic get_request();
      push = 1'b1;
      repeat (10) tick();
      push = 1'b0;
      repeat (7) tick();
      chk("req_raised", req, 1);
   endtask

   // ---------------- directed + random stimulus ----------------
   initial begin
      int lc, ig, rq;
      #1;
      chk("rst_req", req, 0);
      chk("rst_pressed", pressed, 0);
      chk("rst_lock", lock, 0);
      chk("rst_ign", ign, 0);
      chk_en = 1'b1;
      tick(); tick();
      rst = 1'b0;

      // Clean press: pressed at edge 6, request at edge 7, held
      push = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         tick();
         if (i == 5) chk("clean_pressed_e5", pressed, 0);
         if (i == 6) begin chk("clean_pressed_e6", pressed, 1); chk("clean_req_e6", req, 0); end
         if (i == 7) chk("clean_req_e7", req, 1);
      end
      repeat (50) tick();
      chk("req_hold50", req, 1);

      // Ack, cooldown length, release + press during cooldown
      ack = 1'b1;
      tick();
      chk("ack_req", req, 0);
      chk("ack_lock", lock, 1);
      ack = 1'b0; push = 1'b1;
      lc = 1; ig = 0; rq = 0;
      for (int i = 1; i < 40; i++) begin
         if (i == 9) push = 1'b0;
         tick();
         lc += int'(lock); ig += int'(ign); rq += int'(req);
      end
      chk("lock_cycles", lc, 20);
      chk("lock_ignored_pulses", ig, 1);
      chk("lock_req_stays0", rq, 0);

      // Press event on the last cooldown cycle, then ack in IDLE
      get_request();
      ack = 1'b1;
      tick();
      ack = 1'b0; push = 1'b1;
      for (int i = 1; i <= 25; i++) begin
         if (i == 14) push = 1'b0;
         if (i == 22) ack = 1'b1;
         if (i == 23) ack = 1'b0;
         tick();
         if (i == 19) begin chk("last_lock_ign_e19", ign, 0); chk("last_lock_lock_e19", lock, 1); end
         if (i == 20) begin
            chk("last_lock_ign", ign, 1);
            chk("last_lock_lock", lock, 0);
            chk("last_lock_req", req, 0);
         end
      end
      chk("idle_ack_req", req, 0);
      chk("idle_ack_lock", lock, 0);

      // Press event coinciding with ack in REQ
      get_request();
      push = 1'b1;
      repeat (10) tick();
      chk("req_after_release", req, 1);
      push = 1'b0;
      repeat (6) tick();
      chk("coinc_pressed", pressed, 1);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      chk("coinc_lock", lock, 1);
      chk("coinc_req", req, 0);
      chk("coinc_ign", ign, 1);
      repeat (25) tick();

      // Reset mid-REQ, then release with the button held
      get_request();
      rst = 1'b1;
      #1;
      chk("rst_async_req", req, 0);
      chk("rst_async_pressed", pressed, 0);
      repeat (3) tick();
      rst = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         tick();
         if (i == 5) chk("rel_pressed_e5", pressed, 0);
         if (i == 6) begin chk("rel_pressed_e6", pressed, 1); chk("rel_req_e6", req, 0); end
         if (i == 7) chk("rel_req_e7", req, 1);
      end

      // Reset mid-LOCK
      ack = 1'b1;
      tick();
      ack = 1'b0;
      repeat (5) tick();
      chk("midlock_lock", lock, 1);
      rst = 1'b1;
      #1;
      chk("rst_async_lock", lock, 0);
      chk("rst_async_ign", ign, 0);
      tick();
      rst = 1'b0; push = 1'b1;

      // Randomized phase checked by the model
      repeat (3000) begin
         if ($urandom_range(0, 7) == 0) push = ~push;
         ack = ($urandom_range(0, 5) == 0);
         rst = ($urandom_range(0, 399) == 0);
         tick();
      end
      rst = 1'b0; ack = 1'b0;
      repeat (3) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
